// File: rtl/cmd_fetch.sv
// Command fetch engine: sequentially fetches command words from a memory,
// follows jump opcodes, wraps after the last address and flags ack timeouts.
module cmd_fetch #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned MAX_ADR = 4,
   parameter logic [5:0]  JMP_OPC = 6'b111111,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_adr,
   input  logic [31:0]       mem_cmd,
   input  logic              mem_ack,
   output logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic [4:0]        rd,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              err,
   output logic [15:0]       fetch_cnt
);

   localparam int unsigned TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ADR_LAST = ADDR_W'(MAX_ADR);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [TMO_W-1:0]  tmo_nxt;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] adr_nxt;
   logic [31:0]       instr_nxt;
   logic              valid_nxt;
   logic              err_nxt;
   logic [15:0]       cnt_nxt;
   logic              req_nxt;
   logic              busy_nxt;

   // Next-state and next-output computation; every output is registered below.
   always_comb begin
      state_nxt = state;
      tmo_nxt   = tmo_cnt;
      pc_nxt    = pc;
      adr_nxt   = mem_adr;
      instr_nxt = instr;
      valid_nxt = instr_valid;
      err_nxt   = err;
      cnt_nxt   = fetch_cnt;

      case (state)
         S_IDLE: begin
            if (start) begin
               pc_nxt    = '0;
               err_nxt   = 1'b0;
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            tmo_nxt   = '0;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (mem_ack) begin
               instr_nxt = mem_cmd;
               valid_nxt = 1'b1;
               state_nxt = S_OUT;
            end else if (tmo_cnt == TMO_LAST) begin
               err_nxt   = 1'b1;
               tmo_nxt   = '0;
               state_nxt = S_IDLE;
            end else begin
               tmo_nxt = tmo_cnt + TMO_W'(1);
            end
         end
         S_OUT: begin
            if (instr_valid && instr_ready) begin
               valid_nxt = 1'b0;
               cnt_nxt   = fetch_cnt + 16'd1;
               if (opcode == JMP_OPC) begin
                  pc_nxt = instr[ADDR_W-1:0];
               end else if (pc == ADR_LAST) begin
                  pc_nxt = '0;
               end else begin
                  pc_nxt = pc + ADDR_W'(1);
               end
               state_nxt = stop ? S_IDLE : S_REQ;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // The request address is launched together with the strobe
      if (state_nxt == S_REQ) begin
         adr_nxt = pc_nxt;
      end
      req_nxt  = (state_nxt == S_REQ);
      busy_nxt = (state_nxt != S_IDLE);
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         tmo_cnt     <= '0;
         mem_req     <= 1'b0;
         mem_adr     <= '0;
         instr       <= '0;
         opcode      <= '0;
         rd          <= '0;
         instr_valid <= 1'b0;
         pc          <= '0;
         busy        <= 1'b0;
         err         <= 1'b0;
         fetch_cnt   <= '0;
      end else begin
         state       <= state_nxt;
         tmo_cnt     <= tmo_nxt;
         mem_req     <= req_nxt;
         mem_adr     <= adr_nxt;
         instr       <= instr_nxt;
         opcode      <= instr_nxt[31:26];
         rd          <= instr_nxt[25:21];
         instr_valid <= valid_nxt;
         pc          <= pc_nxt;
         busy        <= busy_nxt;
         err         <= err_nxt;
         fetch_cnt   <= cnt_nxt;
      end
   end

endmodule
